bcd_time_editor: RTL and testbench

Parametrised cursor-driven editor for a packed BCD time value of NUM_FIELDS two-digit fields, such as HH:MM:SS. It replaces the fixed three-field chronometer setter. Button edges move a digit cursor and increment or decrement the selected digit under per-field limits, with auto-repeat on held UP/DOWN and a parallel preload path. It sits between the debounced push-button inputs and the timer/chronometer core, which samples `value` and `changed`.

---
 rtl/bcd_time_pkg.sv | 34 +++
 rtl/btn_pulse.sv | 63 ++++++
 rtl/bcd_time_editor.sv | 109 ++++++++++
 tb/tb_bcd_time_editor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_pkg.sv
// Digit limits and clamping helpers shared by the BCD time editor.
// A field is two BCD digits {tens, units}; hour fields run 00-23, all others 00-59.
package bcd_time_pkg;

  localparam logic [3:0] TENS_MAX            = 4'd5;
  localparam logic [3:0] UNITS_MAX           = 4'd9;
  localparam logic [3:0] HOUR_TENS_MAX       = 4'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_2 = 4'd3;

  function automatic logic [3:0] digit_max(input logic field_is_hour,
                                           input logic is_tens,
                                           input logic [3:0] hour_tens);
    if (is_tens)
      return field_is_hour ? HOUR_TENS_MAX : TENS_MAX;
    if (field_is_hour && hour_tens == HOUR_TENS_MAX)
      return HOUR_UNITS_MAX_AT_2;
    return UNITS_MAX;
  endfunction

  // Tens is clamped first so the units limit follows the clamped tens digit.
  function automatic logic [7:0] bcd_clamp_field(input logic field_is_hour,
                                                 input logic [7:0] field);
    logic [3:0] tens;
    logic [3:0] units;
    logic [3:0] tmax;
    logic [3:0] umax;
    tmax  = digit_max(field_is_hour, 1'b1, 4'd0);
    tens  = (field[7:4] > tmax) ? tmax : field[7:4];
    umax  = digit_max(field_is_hour, 1'b0, tens);
    units = (field[3:0] > umax) ? umax : field[3:0];
    return {tens, units};
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button edge detector with optional hold-to-repeat; emits a one-cycle step.
// Steps are gated by en; a button held through reset stays silent until released.
module btn_pulse #(
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 1,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn,
  output logic step
);

  logic prev;
  logic blocked;
  logic press;

  assign press = en & btn & ~prev & ~blocked;

  // prev tracks the level even while disabled, so a button held when en rises gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= 1'b0;
      blocked <= 1'b1;
    end else begin
      prev <= btn;
      if (!btn)
        blocked <= 1'b0;
    end
  end

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

      logic [CW-1:0] cnt;
      logic          active;
      logic          fire;

      assign fire = active & btn & en & (cnt == '0);

      // Down-counter: loaded with DELAY-1 on the press, PERIOD-1 after each repeat.
      always_ff @(posedge clk) begin
        if (reset || !en || !btn) begin
          cnt    <= '0;
          active <= 1'b0;
        end else if (press) begin
          cnt    <= CW'(REPEAT_DELAY - 1);
          active <= 1'b1;
        end else if (active) begin
          cnt <= (cnt == '0) ? CW'(REPEAT_PERIOD - 1) : cnt - CW'(1);
        end
      end

      assign step = press | fire;
    end else begin : g_norep
      assign step = press;
    end
  endgenerate

endmodule

// File: rtl/bcd_time_editor.sv
// Cursor-driven editor for a packed BCD time value (field 0 most significant).
// Buttons move the digit cursor and step the selected digit; load preloads a clamped value.
module bcd_time_editor #(
  parameter int                      NUM_FIELDS    = 3,
  parameter int                      HOUR_FIELD    = 0,
  parameter logic [8*NUM_FIELDS-1:0] RESET_VALUE   = '0,
  parameter int                      REPEAT_DELAY  = 50_000_000,
  parameter int                      REPEAT_PERIOD = 10_000_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            up,
  input  logic                            down,
  input  logic                            left,
  input  logic                            right,
  input  logic                            load,
  input  logic [8*NUM_FIELDS-1:0]         load_value,
  output logic [8*NUM_FIELDS-1:0]         value,
  output logic [$clog2(2*NUM_FIELDS)-1:0] cursor,
  output logic                            changed
);
  import bcd_time_pkg::*;

  localparam int             W        = 8 * NUM_FIELDS;
  localparam int             CW       = $clog2(2 * NUM_FIELDS);
  localparam logic [CW-1:0]  CUR_LAST = CW'(2 * NUM_FIELDS - 1);

  logic up_step, down_step, left_step, right_step;

  btn_pulse #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_up    (.clk(clk), .reset(reset), .en(en), .btn(up),    .step(up_step));
  btn_pulse #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_down  (.clk(clk), .reset(reset), .en(en), .btn(down),  .step(down_step));
  btn_pulse #(.REPEAT_EN(1'b0), .REPEAT_DELAY(1), .REPEAT_PERIOD(1))
    u_left  (.clk(clk), .reset(reset), .en(en), .btn(left),  .step(left_step));
  btn_pulse #(.REPEAT_EN(1'b0), .REPEAT_DELAY(1), .REPEAT_PERIOD(1))
    u_right (.clk(clk), .reset(reset), .en(en), .btn(right), .step(right_step));

  logic [W-1:0]  value_next;
  logic [CW-1:0] cursor_next;
  logic [7:0]    sel_field;
  logic [7:0]    new_field;
  logic [3:0]    sel_digit;
  logic [3:0]    new_digit;
  logic [3:0]    dmax;
  logic          sel_is_hour;
  logic          sel_is_tens;
  logic          do_inc;
  logic          do_dec;
  int            sel_idx;

  always_comb begin
    sel_idx     = int'(cursor >> 1);
    sel_is_tens = ~cursor[0];
    sel_is_hour = (sel_idx == HOUR_FIELD);
    sel_field   = '0;
    for (int i = 0; i < NUM_FIELDS; i++)
      if (i == sel_idx)
        sel_field = value[8*(NUM_FIELDS-i)-1 -: 8];

    sel_digit = sel_is_tens ? sel_field[7:4] : sel_field[3:0];
    dmax      = digit_max(sel_is_hour, sel_is_tens, sel_field[7:4]);
    do_inc    = up_step & ~down_step;
    do_dec    = down_step & ~up_step;

    new_digit = sel_digit;
    if (do_inc)
      new_digit = (sel_digit >= dmax) ? 4'd0 : sel_digit + 4'd1;
    else if (do_dec)
      new_digit = (sel_digit == 4'd0) ? dmax : sel_digit - 4'd1;

    // Re-clamping the whole field pulls hour units down to 3 when tens becomes 2.
    new_field = sel_is_tens ? {new_digit, sel_field[3:0]} : {sel_field[7:4], new_digit};
    new_field = bcd_clamp_field(sel_is_hour, new_field);

    value_next = value;
    if (load) begin
      for (int i = 0; i < NUM_FIELDS; i++)
        value_next[8*(NUM_FIELDS-i)-1 -: 8] =
          bcd_clamp_field(i == HOUR_FIELD, load_value[8*(NUM_FIELDS-i)-1 -: 8]);
    end else if (en && (do_inc || do_dec)) begin
      for (int i = 0; i < NUM_FIELDS; i++)
        if (i == sel_idx)
          value_next[8*(NUM_FIELDS-i)-1 -: 8] = new_field;
    end

    cursor_next = cursor;
    if (!en)
      cursor_next = '0;
    else if (right_step && !left_step)
      cursor_next = (cursor == CUR_LAST) ? '0 : cursor + CW'(1);
    else if (left_step && !right_step)
      cursor_next = (cursor == '0) ? CUR_LAST : cursor - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value   <= RESET_VALUE;
      cursor  <= '0;
      changed <= 1'b0;
    end else begin
      value   <= value_next;
      cursor  <= cursor_next;
      changed <= (value_next != value);
    end
  end

endmodule

// File: tb/tb_bcd_time_editor.sv
// Table-driven bench for bcd_time_editor (HH:MM:SS, short repeat timing).
// Each row is one clock of stimulus; its expected outputs go through a scoreboard queue.
module tb_bcd_time_editor;

  localparam int RD = 4;
  localparam int RP = 2;
  localparam logic [3:0] BU = 4'b1000;
  localparam logic [3:0] BD = 4'b0100;
  localparam logic [3:0] BL = 4'b0010;
  localparam logic [3:0] BR = 4'b0001;
  localparam logic [3:0] B0 = 4'b0000;

  logic        clk = 1'b0;
  logic        reset, en, up, down, left, right, load;
  logic [23:0] load_value;
  logic [23:0] value;
  logic [2:0]  cursor;
  logic        changed;

  always #5 clk = ~clk;

  bcd_time_editor #(
    .NUM_FIELDS(3), .HOUR_FIELD(0), .RESET_VALUE(24'h000000),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .down(down), .left(left), .right(right),
    .load(load), .load_value(load_value), .value(value), .cursor(cursor), .changed(changed)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  btn;
    logic        ld;
    logic [23:0] lv;
    logic [23:0] ev;
    logic [2:0]  ec;
    logic        ech;
  } vec_t;

  typedef struct {
    int          row;
    logic [23:0] ev;
    logic [2:0]  ec;
    logic        ech;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, input logic en_i, input logic [3:0] b, input logic ld,
                     input logic [23:0] lv, input logic [23:0] ev, input logic [2:0] ec,
                     input logic ech);
    vec_t v;
    v.rst = rst; v.en = en_i; v.btn = b; v.ld = ld; v.lv = lv;
    v.ev = ev; v.ec = ec; v.ech = ech;
    tbl.push_back(v);
  endtask

  task automatic idle(input logic en_i, input logic [23:0] ev, input logic [2:0] ec);
    add(1'b0, en_i, B0, 1'b0, 24'h0, ev, ec, 1'b0);
  endtask

  task automatic check(input string name, input int row, input logic [23:0] got,
                       input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got %h want %h", row, name, got, exp);
    end
  endtask

  initial begin
    int   cnt;
    logic stp;
    exp_t e;

    reset = 1'b1; en = 1'b0; {up, down, left, right} = 4'b0; load = 1'b0; load_value = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", -1, value, 24'h000000);
    check("reset_cursor", -1, {21'b0, cursor}, 24'h0);
    check("reset_changed", -1, {23'b0, changed}, 24'h0);

    idle(1'b1, 24'h000000, 3'd0);
    for (int k = 0; k < 6; k++) begin
      add(1'b0, 1'b1, BR, 1'b0, 24'h0, 24'h000000, 3'((k + 1) % 6), 1'b0);
      idle(1'b1, 24'h000000, 3'((k + 1) % 6));
    end

    // minute tens wrap both ways
    add(1'b0, 1'b1, B0, 1'b1, 24'h005000, 24'h005000, 3'd0, 1'b1);
    add(1'b0, 1'b1, BR, 1'b0, 24'h0, 24'h005000, 3'd1, 1'b0); idle(1'b1, 24'h005000, 3'd1);
    add(1'b0, 1'b1, BR, 1'b0, 24'h0, 24'h005000, 3'd2, 1'b0); idle(1'b1, 24'h005000, 3'd2);
    add(1'b0, 1'b1, BU, 1'b0, 24'h0, 24'h000000, 3'd2, 1'b1); idle(1'b1, 24'h000000, 3'd2);
    add(1'b0, 1'b1, BD, 1'b0, 24'h0, 24'h005000, 3'd2, 1'b1); idle(1'b1, 24'h005000, 3'd2);

    // hour tens with units clamp; load while the cursor moves
    add(1'b0, 1'b1, BL, 1'b1, 24'h190000, 24'h190000, 3'd1, 1'b1); idle(1'b1, 24'h190000, 3'd1);
    add(1'b0, 1'b1, BL, 1'b0, 24'h0, 24'h190000, 3'd0, 1'b0); idle(1'b1, 24'h190000, 3'd0);
    add(1'b0, 1'b1, BU, 1'b0, 24'h0, 24'h230000, 3'd0, 1'b1); idle(1'b1, 24'h230000, 3'd0);
    add(1'b0, 1'b1, BU, 1'b0, 24'h0, 24'h030000, 3'd0, 1'b1); idle(1'b1, 24'h030000, 3'd0);
    add(1'b0, 1'b1, BD, 1'b0, 24'h0, 24'h230000, 3'd0, 1'b1); idle(1'b1, 24'h230000, 3'd0);

    // load beats a step; reloading the same value gives no pulse
    add(1'b0, 1'b1, BU, 1'b1, 24'h123456, 24'h123456, 3'd0, 1'b1); idle(1'b1, 24'h123456, 3'd0);
    add(1'b0, 1'b1, B0, 1'b1, 24'h123456, 24'h123456, 3'd0, 1'b0); idle(1'b1, 24'h123456, 3'd0);
    add(1'b0, 1'b1, BU | BD, 1'b0, 24'h0, 24'h123456, 3'd0, 1'b0); idle(1'b1, 24'h123456, 3'd0);
    add(1'b0, 1'b1, BL | BR, 1'b0, 24'h0, 24'h123456, 3'd0, 1'b0); idle(1'b1, 24'h123456, 3'd0);
    add(1'b0, 1'b1, BL, 1'b0, 24'h0, 24'h123456, 3'd5, 1'b0); idle(1'b1, 24'h123456, 3'd5);
    add(1'b0, 1'b1, B0, 1'b1, 24'h000000, 24'h000000, 3'd5, 1'b1); idle(1'b1, 24'h000000, 3'd5);

    // auto-repeat on the seconds units digit
    cnt = 0;
    for (int k = 0; k < 11; k++) begin
      stp = (k == 0) || (k >= RD && ((k - RD) % RP) == 0);
      if (stp) cnt++;
      add(1'b0, 1'b1, BU, 1'b0, 24'h0, 24'(cnt), 3'd5, stp);
    end
    idle(1'b1, 24'h000005, 3'd5);
    idle(1'b1, 24'h000005, 3'd5);

    // step uses the old cursor while the cursor wraps right
    add(1'b0, 1'b1, BU | BR, 1'b0, 24'h0, 24'h000006, 3'd0, 1'b1); idle(1'b1, 24'h000006, 3'd0);
    add(1'b0, 1'b1, BD, 1'b0, 24'h0, 24'h200006, 3'd0, 1'b1); idle(1'b1, 24'h200006, 3'd0);

    // disabled editing
    add(1'b0, 1'b1, BR, 1'b0, 24'h0, 24'h200006, 3'd1, 1'b0); idle(1'b1, 24'h200006, 3'd1);
    idle(1'b0, 24'h200006, 3'd0);
    add(1'b0, 1'b0, BU, 1'b0, 24'h0, 24'h200006, 3'd0, 1'b0); idle(1'b0, 24'h200006, 3'd0);
    add(1'b0, 1'b0, BL, 1'b0, 24'h0, 24'h200006, 3'd0, 1'b0); idle(1'b0, 24'h200006, 3'd0);
    add(1'b0, 1'b0, BU, 1'b0, 24'h0, 24'h200006, 3'd0, 1'b0);
    for (int k = 0; k < 6; k++)
      add(1'b0, 1'b1, BU, 1'b0, 24'h0, 24'h200006, 3'd0, 1'b0);
    idle(1'b1, 24'h200006, 3'd0);
    add(1'b0, 1'b0, B0, 1'b1, 24'h7A6B9F, 24'h235959, 3'd0, 1'b1); idle(1'b0, 24'h235959, 3'd0);

    // reset in the middle of a hold
    idle(1'b1, 24'h235959, 3'd0);
    add(1'b0, 1'b1, BU, 1'b0, 24'h0, 24'h035959, 3'd0, 1'b1);
    add(1'b1, 1'b1, BU, 1'b0, 24'h0, 24'h000000, 3'd0, 1'b0);
    add(1'b1, 1'b1, BU, 1'b0, 24'h0, 24'h000000, 3'd0, 1'b0);
    for (int k = 0; k < 6; k++)
      add(1'b0, 1'b1, BU, 1'b0, 24'h0, 24'h000000, 3'd0, 1'b0);
    idle(1'b1, 24'h000000, 3'd0);
    add(1'b0, 1'b1, BU, 1'b0, 24'h0, 24'h100000, 3'd0, 1'b1); idle(1'b1, 24'h100000, 3'd0);

    // hour units limits: 9 below tens 2, 3 at tens 2
    add(1'b0, 1'b1, BR, 1'b0, 24'h0, 24'h100000, 3'd1, 1'b0); idle(1'b1, 24'h100000, 3'd1);
    add(1'b0, 1'b1, BD, 1'b0, 24'h0, 24'h190000, 3'd1, 1'b1); idle(1'b1, 24'h190000, 3'd1);
    add(1'b0, 1'b1, B0, 1'b1, 24'h230000, 24'h230000, 3'd1, 1'b1); idle(1'b1, 24'h230000, 3'd1);
    add(1'b0, 1'b1, BU, 1'b0, 24'h0, 24'h200000, 3'd1, 1'b1); idle(1'b1, 24'h200000, 3'd1);
    add(1'b0, 1'b1, BD, 1'b0, 24'h0, 24'h230000, 3'd1, 1'b1); idle(1'b1, 24'h230000, 3'd1);

    for (int r = 0; r < tbl.size(); r++) begin
      reset = tbl[r].rst;
      en    = tbl[r].en;
      {up, down, left, right} = tbl[r].btn;
      load       = tbl[r].ld;
      load_value = tbl[r].lv;
      e.row = r; e.ev = tbl[r].ev; e.ec = tbl[r].ec; e.ech = tbl[r].ech;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL row %0d scoreboard: got empty queue want entry", r);
      end else begin
        e = sb.pop_front();
        check("value", e.row, value, e.ev);
        check("cursor", e.row, {21'b0, cursor}, {21'b0, e.ec});
        check("changed", e.row, {23'b0, changed}, {23'b0, e.ech});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
